fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls instruction fetch around the program counter register.
- Drives the instruction-memory read request and decides when the PC advances, either sequentially or to a redirect target.
- Squashes fetches made stale by branch, jump or JR redirects.
- Sits between the PC register, instruction memory and the IF/ID latch; stalls the front end on downstream backpressure and on halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value driven on pc_wdata during reset
SQUASH_W, 16, width of the saturating squash counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
pcaddr  in  32  current PC from the PC register
ihit  in  1  instruction memory returns data this cycle
imemload  in  32  instruction data, valid when ihit=1
redirect_valid  in  1  resolved branch/jump/JR target present (1-cycle pulse)
redirect_addr  in  32  redirect target
stall_i  in  1  IF/ID latch cannot accept an instruction
halt_i  in  1  halt decoded downstream
imemREN  out  1  instruction read request
imemaddr  out  32  instruction read address
pc_we  out  1  PC register loads pc_wdata at the next edge
pc_wdata  out  32  next PC value
fetch_valid  out  1  instr_o holds a deliverable instruction
instr_o  out  32  fetched instruction
halted  out  1  sequencer is in HALTED
squash_cnt  out  SQUASH_W  count of discarded fetches, saturating

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE; imemREN=0, pc_we=0, pc_wdata=RESET_PC, fetch_valid=0, instr_o=0, halted=0, pending redirect flag/address cleared, squash_cnt=0.
- States: IDLE, FETCH, DELIVER, HALTED. State, pending redirect, instr_o, fetch_valid and squash_cnt are registered. imemREN, imemaddr, pc_we and pc_wdata are combinational from state and inputs.
- IDLE: all requests low; always goes to FETCH next cycle (one bubble after reset release).
- FETCH: imemREN=1, imemaddr=pcaddr.
  - redirect_valid=1 and ihit=0: latch redirect_addr into pending; a later redirect overwrites an earlier one (last wins).
  - ihit=1 with pending or same-cycle redirect: pc_we=1, pc_wdata=target; instruction discarded; fetch_valid stays 0; pending cleared; squash_cnt+1; stay in FETCH. A same-cycle redirect takes priority over the latched one.
  - ihit=1, no redirect: pc_we=1, pc_wdata=pcaddr+4; instr_o<=imemload; fetch_valid<=1; go to DELIVER.
- DELIVER: imemREN=0, pc_we=0 unless a redirect occurs.
  - stall_i=0: instruction consumed this cycle; fetch_valid<=0; go to FETCH.
  - stall_i=1: hold instr_o and fetch_valid unchanged.
  - redirect_valid=1: pc_we=1, pc_wdata=redirect_addr; fetch_valid<=0; squash_cnt+1; go to FETCH. Applies regardless of stall_i.
- halt_i=1 in any non-IDLE state: go to HALTED. Halt has priority over redirect and ihit. No pc_we that cycle; fetch_valid<=0.
- HALTED: imemREN=0, pc_we=0, halted=1. Exit only via RST.
- Arithmetic:
  - pcaddr+4 is 32-bit and wraps (32'hFFFF_FFFC -> 0).
  - pc_wdata[1:0] is always forced to 2'b00, including redirect targets.
  - squash_cnt saturates at all-ones.
- ihit is ignored outside FETCH.
- RST asserted mid-fetch aborts immediately; no pc_we follows.

Test Plan:
- Sequential fetch: reset with pcaddr=0, then ihit every FETCH cycle, stall_i=0 -> one IDLE cycle; pc_wdata 4, 8, 12 with pc_we pulses; fetch_valid alternates with each delivered instr_o; squash_cnt=0.
- Redirect during wait: in FETCH with ihit=0, pulse redirect_addr=0x100, ihit 3 cycles later -> pc_wdata=0x100 with pc_we; fetch_valid stays 0; squash_cnt=1.
- Double redirect: redirects 0x200 then 0x300 before ihit -> pc_wdata=0x300; squash_cnt increments by 1 only.
- Stall hold: DELIVER with stall_i=1 for 4 cycles -> instr_o and fetch_valid stable, imemREN=0, no pc_we; stall_i=0 -> FETCH next cycle.
- Halt priority: halt_i=1 with redirect_valid=1 and ihit=1 in FETCH -> no pc_we, halted=1 next cycle, imemREN=0 until RST.
- Wrap/alignment: pcaddr=32'hFFFF_FFFC with ihit -> pc_wdata=0; redirect_addr=0x103 -> pc_wdata=0x100.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its environment
// (PC register, instruction memory, IF/ID latch, downstream control).
interface fetch_sequencer_if #(
    parameter int unsigned SQUASH_W = 16
);
    logic [31:0]         pcaddr;
    logic                ihit;
    logic [31:0]         imemload;
    logic                redirect_valid;
    logic [31:0]         redirect_addr;
    logic                stall_i;
    logic                halt_i;
    logic                imemREN;
    logic [31:0]         imemaddr;
    logic                pc_we;
    logic [31:0]         pc_wdata;
    logic                fetch_valid;
    logic [31:0]         instr_o;
    logic                halted;
    logic [SQUASH_W-1:0] squash_cnt;

    modport master (
        input  pcaddr, ihit, imemload, redirect_valid, redirect_addr, stall_i, halt_i,
        output imemREN, imemaddr, pc_we, pc_wdata, fetch_valid, instr_o, halted, squash_cnt
    );

    modport slave (
        output pcaddr, ihit, imemload, redirect_valid, redirect_addr, stall_i, halt_i,
        input  imemREN, imemaddr, pc_we, pc_wdata, fetch_valid, instr_o, halted, squash_cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Front-end fetch control: issues instruction reads, advances or redirects the PC,
// squashes stale fetches and holds fetched instructions against IF/ID backpressure.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned SQUASH_W = 16
) (
    input logic                CLK,
    input logic                RST,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StDeliver, StHalted} state_e;

    state_e                state_q, state_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [31:0]           pend_addr_q, pend_addr_d;
    logic [31:0]           instr_q, instr_d;
    logic                  fv_q, fv_d;
    logic [SQUASH_W-1:0]   squash_q, squash_d;

    logic                  ren;
    logic                  we;
    logic                  squash;
    logic [31:0]           target;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        instr_d      = instr_q;
        fv_d         = fv_q;
        ren          = 1'b0;
        we           = 1'b0;
        squash       = 1'b0;
        target       = RESET_PC;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                ren = 1'b1;
                if (bus.halt_i) begin
                    state_d = StHalted;
                    fv_d    = 1'b0;
                end else if (bus.ihit) begin
                    we = 1'b1;
                    // A redirect arriving with the data beats any latched one.
                    if (bus.redirect_valid) begin
                        target       = bus.redirect_addr;
                        squash       = 1'b1;
                        pend_valid_d = 1'b0;
                    end else if (pend_valid_q) begin
                        target       = pend_addr_q;
                        squash       = 1'b1;
                        pend_valid_d = 1'b0;
                    end else begin
                        target  = bus.pcaddr + 32'd4;
                        instr_d = bus.imemload;
                        fv_d    = 1'b1;
                        state_d = StDeliver;
                    end
                end else if (bus.redirect_valid) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = bus.redirect_addr;
                end
            end
            StDeliver: begin
                if (bus.halt_i) begin
                    state_d = StHalted;
                    fv_d    = 1'b0;
                end else if (bus.redirect_valid) begin
                    we      = 1'b1;
                    target  = bus.redirect_addr;
                    squash  = 1'b1;
                    fv_d    = 1'b0;
                    state_d = StFetch;
                end else if (!bus.stall_i) begin
                    fv_d    = 1'b0;
                    state_d = StFetch;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase

        squash_d = (squash && (squash_q != '1)) ? squash_q + SQUASH_W'(1) : squash_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'd0;
            instr_q      <= 32'd0;
            fv_q         <= 1'b0;
            squash_q     <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            instr_q      <= instr_d;
            fv_q         <= fv_d;
            squash_q     <= squash_d;
        end
    end

    assign bus.imemREN     = ren;
    assign bus.imemaddr    = bus.pcaddr;
    assign bus.pc_we       = we;
    assign bus.pc_wdata    = {target[31:2], 2'b00};
    assign bus.fetch_valid = fv_q;
    assign bus.instr_o     = instr_q;
    assign bus.halted      = (state_q == StHalted);
    assign bus.squash_cnt  = squash_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written
// halt/reset sequences, then random closed-loop traffic against a behavioural model.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fetch_sequencer_if #(.SQUASH_W(16)) bus ();

    fetch_sequencer #(
        .RESET_PC (RST_PC),
        .SQUASH_W (16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic        ihit;
        logic [31:0] ld;
        logic        rv;
        logic [31:0] ra;
        logic        st;
        logic        ht;
        logic        e_ren;
        logic        e_we;
        logic [31:0] e_wd;
        logic        e_fv;
        logic [31:0] e_in;
        logic [15:0] e_sq;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic ih, input logic [31:0] ld,
                         input logic rv, input logic [31:0] ra, input logic st,
                         input logic ht);
        bus.pcaddr         = pc;
        bus.ihit           = ih;
        bus.imemload       = ld;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
        bus.stall_i        = st;
        bus.halt_i         = ht;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] pc, input logic e_ren,
                              input logic e_we, input logic [31:0] e_wd, input logic e_fv,
                              input logic [31:0] e_in, input logic e_ht,
                              input logic [15:0] e_sq);
        chk({tag, ".imemREN"}, 32'(bus.imemREN), 32'(e_ren));
        if (e_ren) chk({tag, ".imemaddr"}, bus.imemaddr, pc);
        chk({tag, ".pc_we"}, 32'(bus.pc_we), 32'(e_we));
        if (e_we) chk({tag, ".pc_wdata"}, bus.pc_wdata, e_wd);
        chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(e_fv));
        chk({tag, ".instr_o"}, bus.instr_o, e_in);
        chk({tag, ".halted"}, 32'(bus.halted), 32'(e_ht));
        chk({tag, ".squash_cnt"}, 32'(bus.squash_cnt), 32'(e_sq));
    endtask

    // Called on a falling edge; returns on the next falling edge with RST released.
    task automatic do_reset();
        RST = 1'b1;
        drive(32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("rst.imemREN", 32'(bus.imemREN), 32'd0);
        chk("rst.pc_we", 32'(bus.pc_we), 32'd0);
        chk("rst.pc_wdata", bus.pc_wdata, RST_PC);
        chk("rst.fetch_valid", 32'(bus.fetch_valid), 32'd0);
        chk("rst.instr_o", bus.instr_o, 32'd0);
        chk("rst.halted", 32'(bus.halted), 32'd0);
        chk("rst.squash_cnt", 32'(bus.squash_cnt), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic ih, input logic [31:0] ld,
                                input logic rv, input logic [31:0] ra, input logic st,
                                input logic ht, input logic e_ren, input logic e_we,
                                input logic [31:0] e_wd, input logic e_fv,
                                input logic [31:0] e_in, input logic [15:0] e_sq);
        vec_t v;
        v.pc = pc; v.ihit = ih; v.ld = ld; v.rv = rv; v.ra = ra; v.st = st; v.ht = ht;
        v.e_ren = e_ren; v.e_we = e_we; v.e_wd = e_wd; v.e_fv = e_fv; v.e_in = e_in;
        v.e_sq = e_sq;
        return v;
    endfunction

    // Behavioural model: bubble after reset, an instruction held for delivery,
    // a stopped flag, and a queue of outstanding redirects whose newest entry wins.
    bit          m_bub, m_hold, m_stop;
    int          m_stop_cyc;
    logic [31:0] m_redir[$];
    logic [31:0] m_pc, m_instr;
    int unsigned m_sq;

    task automatic model_reset();
        m_bub = 1'b1; m_hold = 1'b0; m_stop = 1'b0; m_stop_cyc = 0;
        m_redir.delete();
        m_pc = RST_PC; m_instr = 32'd0; m_sq = 0;
    endtask

    initial begin
        logic        r_ih, r_rv, r_st, r_ht;
        logic [31:0] r_ld, r_ra;
        logic        e_ren, e_we;
        logic [31:0] e_wd;

        // Sequential fetch, redirect in wait, double redirect, stall hold, wrap/alignment.
        tbl.push_back(mk(32'h0,   1, 32'h1111_0000, 0, 0, 0, 0, 0, 0, 0,        0, 32'h0, 0));
        tbl.push_back(mk(32'h0,   1, 32'hAAAA_0001, 0, 0, 0, 0, 1, 1, 32'h4,    0, 32'h0, 0));
        tbl.push_back(mk(32'h4,   0, 32'h0,         0, 0, 0, 0, 0, 0, 0,        1, 32'hAAAA_0001, 0));
        tbl.push_back(mk(32'h4,   1, 32'hAAAA_0002, 0, 0, 0, 0, 1, 1, 32'h8,    0, 32'hAAAA_0001, 0));
        tbl.push_back(mk(32'h8,   0, 32'h0,         0, 0, 0, 0, 0, 0, 0,        1, 32'hAAAA_0002, 0));
        tbl.push_back(mk(32'h8,   1, 32'hAAAA_0003, 0, 0, 0, 0, 1, 1, 32'hC,    0, 32'hAAAA_0002, 0));
        tbl.push_back(mk(32'hC,   0, 32'h0,         0, 0, 0, 0, 0, 0, 0,        1, 32'hAAAA_0003, 0));
        tbl.push_back(mk(32'hC,   0, 32'h0,   1, 32'h100, 0, 0, 1, 0, 0,        0, 32'hAAAA_0003, 0));
        tbl.push_back(mk(32'hC,   0, 32'h0,         0, 0, 0, 0, 1, 0, 0,        0, 32'hAAAA_0003, 0));
        tbl.push_back(mk(32'hC,   0, 32'h0,         0, 0, 0, 0, 1, 0, 0,        0, 32'hAAAA_0003, 0));
        tbl.push_back(mk(32'hC,   1, 32'hDEAD_0000, 0, 0, 0, 0, 1, 1, 32'h100,  0, 32'hAAAA_0003, 0));
        tbl.push_back(mk(32'h100, 0, 32'h0,   1, 32'h200, 0, 0, 1, 0, 0,        0, 32'hAAAA_0003, 1));
        tbl.push_back(mk(32'h100, 0, 32'h0,   1, 32'h300, 0, 0, 1, 0, 0,        0, 32'hAAAA_0003, 1));
        tbl.push_back(mk(32'h100, 1, 32'hDEAD_0001, 0, 0, 0, 0, 1, 1, 32'h300,  0, 32'hAAAA_0003, 1));
        tbl.push_back(mk(32'h300, 1, 32'hBBBB_0001, 0, 0, 0, 0, 1, 1, 32'h304,  0, 32'hAAAA_0003, 2));
        tbl.push_back(mk(32'h304, 0, 32'h0,         0, 0, 1, 0, 0, 0, 0,        1, 32'hBBBB_0001, 2));
        tbl.push_back(mk(32'h304, 1, 32'hEEEE_0000, 0, 0, 1, 0, 0, 0, 0,        1, 32'hBBBB_0001, 2));
        tbl.push_back(mk(32'h304, 0, 32'h0,         0, 0, 1, 0, 0, 0, 0,        1, 32'hBBBB_0001, 2));
        tbl.push_back(mk(32'h304, 0, 32'h0,         0, 0, 1, 0, 0, 0, 0,        1, 32'hBBBB_0001, 2));
        tbl.push_back(mk(32'h304, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0,        1, 32'hBBBB_0001, 2));
        tbl.push_back(mk(32'h304, 0, 32'h0,         0, 0, 0, 0, 1, 0, 0,        0, 32'hBBBB_0001, 2));
        tbl.push_back(mk(32'hFFFF_FFFC, 1, 32'hCCCC_0001, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'hBBBB_0001, 2));
        tbl.push_back(mk(32'h0,   0, 32'h0,   1, 32'h103, 1, 0, 0, 1, 32'h100,  1, 32'hCCCC_0001, 2));
        tbl.push_back(mk(32'h100, 1, 32'h0,   1, 32'h207, 0, 0, 1, 1, 32'h204,  0, 32'hCCCC_0001, 3));
        tbl.push_back(mk(32'h204, 0, 32'h0,         0, 0, 0, 0, 1, 0, 0,        0, 32'hCCCC_0001, 4));

        RST = 1'b1;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pc, tbl[i].ihit, tbl[i].ld, tbl[i].rv, tbl[i].ra, tbl[i].st, tbl[i].ht);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].e_ren, tbl[i].e_we,
                       tbl[i].e_wd, tbl[i].e_fv, tbl[i].e_in, 1'b0, tbl[i].e_sq);
            @(negedge CLK);
        end

        // Halt beats a simultaneous redirect and ihit, then holds until reset.
        drive(32'h204, 1'b1, 32'h5555_5555, 1'b1, 32'h500, 1'b0, 1'b1);
        #1;
        chk("halt.pc_we", 32'(bus.pc_we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            drive(32'h204, 1'b1, 32'h6666_6666, 1'b1, 32'h600, 1'b0, 1'b0);
            #1;
            check_outs($sformatf("halted%0d", i), 32'h204, 1'b0, 1'b0, 32'h0, 1'b0,
                       32'hCCCC_0001, 1'b1, 16'd4);
        end
        @(negedge CLK);
        do_reset();

        // Reset landing on the same cycle as ihit must not produce a PC write.
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        #1;
        chk("midrst.fetching", 32'(bus.imemREN), 32'd1);
        @(negedge CLK);
        drive(32'h0, 1'b1, 32'h7777_7777, 1'b0, 32'h0, 1'b0, 1'b0);
        RST = 1'b1;
        #1;
        chk("midrst.pc_we", 32'(bus.pc_we), 32'd0);
        chk("midrst.imemREN", 32'(bus.imemREN), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();

        // Random closed loop: the model plays the PC register and predicts every output.
        for (int c = 0; c < 3000; c++) begin
            if (m_stop && m_stop_cyc >= 3) begin
                do_reset();
                model_reset();
                continue;
            end
            r_ih = 1'($urandom_range(0, 1));
            r_rv = ($urandom_range(0, 4) == 0);
            r_st = ($urandom_range(0, 2) != 0);
            r_ht = ($urandom_range(0, 149) == 0);
            r_ld = $urandom;
            r_ra = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                               : $urandom;
            drive(m_pc, r_ih, r_ld, r_rv, r_ra, r_st, r_ht);

            e_ren = 1'b0; e_we = 1'b0; e_wd = 32'h0;
            if (!m_stop && !m_bub) begin
                if (m_hold) begin
                    e_we = !r_ht && r_rv;
                    e_wd = r_ra;
                end else begin
                    e_ren = 1'b1;
                    e_we  = !r_ht && r_ih;
                    if (r_rv)                   e_wd = r_ra;
                    else if (m_redir.size() > 0) e_wd = m_redir[$];
                    else                        e_wd = m_pc + 32'd4;
                end
            end
            e_wd = e_wd & 32'hFFFF_FFFC;
            #1;
            check_outs("rand", m_pc, e_ren, e_we, e_wd, m_hold, m_instr, m_stop, 16'(m_sq));

            @(posedge CLK);
            if (m_stop) begin
                m_stop_cyc++;
            end else if (m_bub) begin
                m_bub = 1'b0;
            end else if (r_ht) begin
                m_stop = 1'b1; m_hold = 1'b0; m_stop_cyc = 0;
            end else if (m_hold) begin
                if (r_rv) begin
                    m_hold = 1'b0;
                    if (m_sq < 65535) m_sq++;
                end else if (!r_st) begin
                    m_hold = 1'b0;
                end
            end else if (r_ih) begin
                if (r_rv || m_redir.size() > 0) begin
                    if (m_sq < 65535) m_sq++;
                    m_redir.delete();
                end else begin
                    m_instr = r_ld;
                    m_hold  = 1'b1;
                end
            end else if (r_rv) begin
                m_redir.push_back(r_ra);
            end
            if (e_we) m_pc = e_wd;
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
